// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: control-word layout, ALUOp encodings
// and the ID/EX hazard state encoding.
package mips_pkg;

    localparam int unsigned CTRL_W  = 10;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUOP_W = 2;

    // Bit positions inside the 10-bit control word
    localparam int unsigned REGWRITE = 9;
    localparam int unsigned MEMREAD  = 8;
    localparam int unsigned MEMWRITE = 7;
    localparam int unsigned MEMTOREG = 6;
    localparam int unsigned ALUSRC   = 5;
    localparam int unsigned REGDST   = 4;
    localparam int unsigned BRANCH   = 3;
    localparam int unsigned JUMP     = 2;
    localparam int unsigned ALUOP    = 0;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

    typedef enum logic {
        HZ_IDLE  = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the ID instruction and a load sitting in EX.
// Produces the PC / IF-ID write enables; a flush overrides the stall.
module hazard_detect
    import mips_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             flush,
    output logic             lu_c,
    output logic             pc_write,
    output logic             if_id_write
);

    assign lu_c = id_valid && ex_valid && ex_memread && (ex_rt != '0)
               && ((ex_rt == id_rs) || (ex_rt == id_rt));

    assign pc_write    = !(lu_c && !flush);
    assign if_id_write = !(lu_c && !flush);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use bubble insertion,
// flush bubbles and a saturating stall-cycle counter.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned CNTW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DW-1:0]     id_rdata1,
    input  logic [DW-1:0]     id_rdata2,
    input  logic [DW-1:0]     id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_w,
    input  logic [DW-1:0]     wb_wdata,
    input  logic              flush,
    output logic              ex_valid,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DW-1:0]     ex_a,
    output logic [DW-1:0]     ex_b,
    output logic [DW-1:0]     ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [CNTW-1:0]   stall_count
);

    logic          lu_c;
    logic          stall_c;
    logic          bubble_c;
    logic [DW-1:0] a_c;
    logic [DW-1:0] b_c;
    hz_state_e     state;
    hz_state_e     state_next;

    hazard_detect u_hazard (
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .ex_valid    (ex_valid),
        .ex_memread  (ex_ctrl[MEMREAD]),
        .ex_rt       (ex_rt),
        .flush       (flush),
        .lu_c        (lu_c),
        .pc_write    (pc_write),
        .if_id_write (if_id_write)
    );

    assign stall_c  = lu_c && !flush;
    assign bubble_c = flush || lu_c;

    // Same-cycle register-file write wins over the stale read data; r0 never bypasses
    always_comb begin
        a_c = id_rdata1;
        b_c = id_rdata2;
        if (wb_regwrite && (wb_w != '0) && (wb_w == id_rs)) a_c = wb_wdata;
        if (wb_regwrite && (wb_w != '0) && (wb_w == id_rt)) b_c = wb_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= HZ_IDLE;
        else       state <= state_next;
    end

    // A stall is always exactly one cycle long
    always_comb begin
        state_next = state;
        case (state)
            HZ_IDLE:  if (stall_c) state_next = HZ_STALL;
            HZ_STALL: state_next = HZ_IDLE;
            default:  state_next = HZ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || bubble_c) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= BUBBLE_CTRL;
        end else begin
            ex_valid <= id_valid;
            ex_rs    <= id_rs;
            ex_rt    <= id_rt;
            ex_rd    <= id_rd;
            ex_a     <= a_c;
            ex_b     <= b_c;
            ex_imm   <= id_imm;
            ex_ctrl  <= id_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                              stall_count <= '0;
        else if (stall_c && (stall_count != '1)) stall_count <= stall_count + CNTW'(1);
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand sequences
// and random stimulus against a behavioural pipeline-register model.
module tb_id_ex_stage;

    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic [9:0]  id_ctrl;
    logic        wb_regwrite;
    logic [4:0]  wb_w;
    logic [31:0] wb_wdata;
    logic        flush;

    logic        ex_valid, pc_write, if_id_write;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [9:0]  ex_ctrl;
    logic [15:0] stall_count;

    logic        ex_valid4, pc_write4, if_id_write4;
    logic [4:0]  ex_rs4, ex_rt4, ex_rd4;
    logic [31:0] ex_a4, ex_b4, ex_imm4;
    logic [9:0]  ex_ctrl4;
    logic [3:0]  stall_count4;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .wb_regwrite(wb_regwrite), .wb_w(wb_w), .wb_wdata(wb_wdata),
        .flush(flush), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
    );

    id_ex_stage #(.DW(DW), .CNTW(4)) dut4 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_ctrl(id_ctrl), .wb_regwrite(wb_regwrite), .wb_w(wb_w), .wb_wdata(wb_wdata),
        .flush(flush), .ex_valid(ex_valid4), .ex_rs(ex_rs4), .ex_rt(ex_rt4), .ex_rd(ex_rd4),
        .ex_a(ex_a4), .ex_b(ex_b4), .ex_imm(ex_imm4), .ex_ctrl(ex_ctrl4),
        .pc_write(pc_write4), .if_id_write(if_id_write4), .stall_count(stall_count4)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what EX should hold, plus ideal stall tallies
    logic        m_valid;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [31:0] m_a, m_b, m_imm;
    logic [9:0]  m_ctrl;
    int          m_stalls;

    function automatic bit model_lu();
        return id_valid && m_valid && m_ctrl[8] && (m_rt != 0) && (m_rt == id_rs || m_rt == id_rt);
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
        return (wb_regwrite && wb_w != 0 && wb_w == r) ? wb_wdata : rf;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_rs = 0; m_rt = 0; m_rd = 0;
        m_a = 0; m_b = 0; m_imm = 0; m_ctrl = 0;
    endtask

    // One clock: check combinational enables, advance the model, check registers
    task automatic step();
        bit lu;
        lu = model_lu();
        #3;
        if (!reset) begin
            chk("pc_write", 32'(pc_write), 32'(!(lu && !flush)));
            chk("if_id_write", 32'(if_id_write), 32'(!(lu && !flush)));
            chk("pc_write4", 32'(pc_write4), 32'(!(lu && !flush)));
        end
        @(posedge clk);
        if (reset) begin
            model_clear();
            m_stalls = 0;
        end else if (flush || lu) begin
            model_clear();
            if (!flush) m_stalls++;
        end else begin
            m_valid = id_valid; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            m_a = operand(id_rs, id_rdata1); m_b = operand(id_rt, id_rdata2);
            m_imm = id_imm; m_ctrl = id_ctrl;
        end
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("ex_rs", 32'(ex_rs), 32'(m_rs));
        chk("ex_rt", 32'(ex_rt), 32'(m_rt));
        chk("ex_rd", 32'(ex_rd), 32'(m_rd));
        chk("ex_a", ex_a, m_a);
        chk("ex_b", ex_b, m_b);
        chk("ex_imm", ex_imm, m_imm);
        chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
        chk("stall_count", 32'(stall_count), (m_stalls > 65535) ? 32'd65535 : 32'(m_stalls));
        chk("stall_count4", 32'(stall_count4), (m_stalls > 15) ? 32'd15 : 32'(m_stalls));
        chk("ex_valid4", 32'(ex_valid4), 32'(m_valid));
        chk("ex_a4", ex_a4, m_a);
    endtask

    task automatic set_in(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] imm, input logic [9:0] ctrl, input logic wrw,
                          input logic [4:0] ww, input logic [31:0] wd, input logic fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rdata1 = r1; id_rdata2 = r2; id_imm = imm; id_ctrl = ctrl;
        wb_regwrite = wrw; wb_w = ww; wb_wdata = wd; flush = fl;
    endtask

    task automatic rand_in();
        set_in(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom), $urandom, $urandom, $urandom, 10'($urandom),
               1'($urandom), 5'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 7) == 0));
    endtask

    typedef struct {
        logic        v;
        logic [4:0]  rs, rt;
        logic [31:0] r1, r2, imm;
        logic [9:0]  ctrl;
        logic        wrw;
        logic [4:0]  ww;
        logic [31:0] wd;
        logic        fl;
        logic        e_pc, e_valid;
        logic [31:0] e_a, e_b;
        logic [9:0]  e_ctrl;
        int          e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [31:0] imm, input logic [9:0] ctrl, input logic wrw,
                                input logic [4:0] ww, input logic [31:0] wd, input logic fl,
                                input logic e_pc, input logic e_valid, input logic [31:0] e_a,
                                input logic [31:0] e_b, input logic [9:0] e_ctrl, input int e_cnt);
        vec_t t;
        t.v = v; t.rs = rs; t.rt = rt; t.r1 = r1; t.r2 = r2; t.imm = imm; t.ctrl = ctrl;
        t.wrw = wrw; t.ww = ww; t.wd = wd; t.fl = fl; t.e_pc = e_pc; t.e_valid = e_valid;
        t.e_a = e_a; t.e_b = e_b; t.e_ctrl = e_ctrl; t.e_cnt = e_cnt;
        return t;
    endfunction

    localparam logic [9:0] C_ADD = 10'h202;  // RegWrite, ALUOp=10
    localparam logic [9:0] C_LW  = 10'h360;  // RegWrite, MemRead, MemtoReg, ALUSrc

    vec_t tbl[15];

    initial begin
        // Each row is one cycle; expected values are what EX holds after the edge
        tbl[0]  = mk(1, 8,  9,  9,   4,  0, C_ADD, 0, 0, 0,  0, 1, 1, 9,   4,  C_ADD, 0);
        tbl[1]  = mk(1, 8,  3,  9,   6,  0, C_ADD, 1, 8, 77, 0, 1, 1, 77,  6,  C_ADD, 0);
        tbl[2]  = mk(1, 0,  0,  0,   0,  0, C_ADD, 1, 0, 5,  0, 1, 1, 0,   0,  C_ADD, 0);
        tbl[3]  = mk(1, 2,  10, 100, 55, 4, C_LW,  0, 0, 0,  0, 1, 1, 100, 55, C_LW,  0);
        tbl[4]  = mk(1, 10, 11, 7,   8,  0, C_ADD, 0, 0, 0,  0, 0, 0, 0,   0,  10'h0, 1);
        tbl[5]  = mk(1, 10, 11, 7,   8,  0, C_ADD, 0, 0, 0,  0, 1, 1, 7,   8,  C_ADD, 1);
        tbl[6]  = mk(1, 2,  10, 100, 55, 4, C_LW,  0, 0, 0,  0, 1, 1, 100, 55, C_LW,  1);
        tbl[7]  = mk(1, 10, 11, 7,   8,  0, C_ADD, 0, 0, 0,  1, 1, 0, 0,   0,  10'h0, 1);
        tbl[8]  = mk(1, 2,  10, 100, 55, 4, C_LW,  0, 0, 0,  0, 1, 1, 100, 55, C_LW,  1);
        tbl[9]  = mk(1, 0,  10, 3,   4,  0, C_ADD, 0, 0, 0,  0, 0, 0, 0,   0,  10'h0, 2);
        tbl[10] = mk(0, 0,  10, 1,   2,  0, 10'h0, 0, 0, 0,  0, 1, 0, 1,   2,  10'h0, 2);
        tbl[11] = mk(1, 1,  0,  11,  12, 0, C_LW,  0, 0, 0,  0, 1, 1, 11,  12, C_LW,  2);
        tbl[12] = mk(1, 0,  0,  13,  14, 0, C_ADD, 0, 0, 0,  0, 1, 1, 13,  14, C_ADD, 2);
        tbl[13] = mk(1, 2,  10, 100, 55, 4, C_LW,  0, 0, 0,  0, 1, 1, 100, 55, C_LW,  2);
        tbl[14] = mk(0, 10, 10, 21,  22, 0, C_ADD, 0, 0, 0,  0, 1, 0, 21,  22, C_ADD, 2);

        model_clear();
        m_stalls = 0;

        // Reset held two cycles with random inputs
        reset = 1;
        rand_in();
        step();
        rand_in();
        step();
        reset = 0;
        rand_in();
        #2;
        chk("rst_pc_write", 32'(pc_write), 32'd1);
        chk("rst_if_id_write", 32'(if_id_write), 32'd1);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_a", ex_a, 32'd0);
        chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
        chk("rst_stall_count", 32'(stall_count), 32'd0);
        #1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].v, tbl[i].rs, tbl[i].rt, 5'd0, tbl[i].r1, tbl[i].r2, tbl[i].imm,
                   tbl[i].ctrl, tbl[i].wrw, tbl[i].ww, tbl[i].wd, tbl[i].fl);
            #2;
            chk($sformatf("vec%0d_pc_write", i), 32'(pc_write), 32'(tbl[i].e_pc));
            chk($sformatf("vec%0d_if_id_write", i), 32'(if_id_write), 32'(tbl[i].e_pc));
            step();
            chk($sformatf("vec%0d_ex_valid", i), 32'(ex_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d_ex_a", i), ex_a, tbl[i].e_a);
            chk($sformatf("vec%0d_ex_b", i), ex_b, tbl[i].e_b);
            chk($sformatf("vec%0d_ex_ctrl", i), 32'(ex_ctrl), 32'(tbl[i].e_ctrl));
            chk($sformatf("vec%0d_stall_count", i), 32'(stall_count), 32'(tbl[i].e_cnt));
        end

        // Saturation: 20 load/use pairs, then two more
        for (int i = 0; i < 22; i++) begin
            set_in(1, 2, 10, 0, 100, 55, 4, C_LW, 0, 0, 0, 0);
            step();
            set_in(1, 10, 11, 0, 7, 8, 0, C_ADD, 0, 0, 0, 0);
            step();
            if (i == 19) chk("sat20_count4", 32'(stall_count4), 32'd15);
        end
        chk("sat22_count4", 32'(stall_count4), 32'd15);

        // Reset raised while a stall is pending
        set_in(1, 2, 10, 0, 100, 55, 4, C_LW, 0, 0, 0, 0);
        step();
        set_in(1, 10, 11, 0, 7, 8, 0, C_ADD, 0, 0, 0, 0);
        reset = 1;
        step();
        reset = 0;
        #2;
        chk("rst_stall_pc_write", 32'(pc_write), 32'd1);
        chk("rst_stall_count", 32'(stall_count), 32'd0);
        #1;
        step();
        chk("rst_stall_capture", ex_a, 32'd7);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rand_in();
            reset = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the 5-stage MIPS core, directly downstream of the register file. Each cycle it captures the two register-file read ports, the sign-extended immediate, register numbers and decoded control. Between decode and capture it applies a write-back bypass for same-cycle register writes, detects load-use hazards and inserts bubbles on stall or branch flush. It also keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- `DW`, 32, datapath width
- `CNTW`, 16, stall counter width

Ports:
- `clk` in 1: rising-edge clock
- `reset` in 1: synchronous, active-high; the only reset
- `id_valid` in 1: instruction in ID is real (0 = bubble)
- `id_rs`, `id_rt`, `id_rd` in 5 each: register numbers of the ID instruction
- `id_rdata1`, `id_rdata2` in DW each: register-file `Out1`/`Out2`
- `id_imm` in DW: sign-extended immediate
- `id_ctrl` in 10: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, Branch, Jump, ALUOp[1:0]}
- `wb_regwrite` in 1, `wb_w` in 5, `wb_wdata` in DW: the write port currently driving the register file
- `flush` in 1: taken branch/jump resolved downstream; kill the ID instruction
- `ex_valid` out 1, `ex_rs`/`ex_rt`/`ex_rd` out 5, `ex_a`/`ex_b`/`ex_imm` out DW, `ex_ctrl` out 10: registered ID/EX contents
- `pc_write` out 1, `if_id_write` out 1: combinational; 0 freezes PC and IF/ID
- `stall_count` out CNTW: saturating count of load-use stall cycles

## Operation
- Bypass (combinational, per operand): if `wb_regwrite` && `wb_w`!=0 && `wb_w`==`id_rs`, the A operand is `wb_wdata`; otherwise it is `id_rdata1`. The B operand uses the same rule with `id_rt` and `id_rdata2`. Register 0 never bypasses.
- Load-use hazard `lu` = `id_valid` && `ex_valid` && `ex_ctrl.MemRead` && `ex_rt`!=0 && (`ex_rt`==`id_rs` || `ex_rt`==`id_rt`).
- Priority each cycle, highest first:
  - `flush`: capture a bubble. `pc_write`=`if_id_write`=1. `lu` is ignored.
  - `lu`: capture a bubble. `pc_write`=`if_id_write`=0. `stall_count` increments, saturating at all-ones.
  - Otherwise: capture the ID fields with `ex_valid`=`id_valid`.
- Bubble: `ex_valid`=0 and `ex_ctrl`=0. Data and register-number fields are also zeroed so the bubble is deterministic.
- A stall lasts exactly one cycle. After it, `ex_ctrl.MemRead` belongs to a bubble, so `lu` clears and the held ID instruction proceeds.
- Hazard state machine: two states. IDLE goes to STALL on `lu` && !`flush`. STALL always returns to IDLE. A flush in STALL returns to IDLE and issues a bubble. The state is a debug aid only; it is not exported.

## Timing
- All ID/EX outputs are registered and update on rising `clk`, with a latency of 1 cycle from the ID inputs.
- `pc_write` and `if_id_write` depend combinationally on the current inputs and the registered EX fields, in the same cycle.
- Reset values while `reset` is high at an edge:
  - all `ex_*` = 0, `ex_valid` = 0, `stall_count` = 0, state = IDLE.
  - `pc_write` and `if_id_write` evaluate to 1, because `ex_valid` is 0.
- Reset raised during a stall: the stall is abandoned and the next cycle is IDLE with a bubble in EX.
- Simultaneous `flush` and `lu`: flush wins and `stall_count` does not increment.
- WB write to the same register as `id_rs`/`id_rt` in the same cycle: the captured operand is `wb_wdata`, never the stale register-file value.

## Structure
- `mips_pkg` holds:
  - the control-bit index constants (REGWRITE … ALUOP),
  - the ALUOp encodings,
  - the `CTRL_W`=10 constant,
  - a `BUBBLE_CTRL` constant of zero.
- Sub-module `hazard_detect` (combinational `lu`, `pc_write`, `if_id_write`) is instantiated inside `id_ex_stage`. A later forwarding unit reuses it.

## Test plan
- Reset: hold `reset` for 2 cycles with random inputs. Required: all `ex_*`=0, `pc_write`=1, `stall_count`=0.
- Plain capture: rs=8, rt=9, `id_rdata1`=9, `id_rdata2`=4, `id_ctrl` RegWrite=1, ALUOp=2'b10. Required: next cycle `ex_a`=9, `ex_b`=4, `ex_valid`=1, ctrl matches.
- WB bypass:
  - Write $t0 (`wb_w`=8, `wb_wdata`=77) in the same cycle as ID reads rs=8 with `id_rdata1`=9. Required: `ex_a`=77.
  - Repeat with `wb_w`=0, rs=0, `id_rdata1`=0, `wb_wdata`=5. Required: `ex_a`=0.
- Load-use stall: EX holds lw with `ex_rt`=10 and MemRead=1, and ID reads rs=10.
  - Required: `pc_write`=`if_id_write`=0 for exactly 1 cycle, EX gets a bubble, `stall_count`=1.
  - Required: the following cycle captures the held instruction.
- Flush vs stall: the same lw/use pair with `flush`=1. Required: bubble, `pc_write`=1, `stall_count` unchanged.
- Saturation: with CNTW=4, force 20 consecutive stalls. Required: `stall_count`=15 and it stays at 15.
